// File: rtl/carfield_eoc_tap.sv
`default_nettype none
// ============================================================================
// Module   : carfield_eoc_tap
// Brief    : JTAG TAP exposing IDCODE, a 64-bit entry/run register and an
//            end-of-computation sticky flag with latest exit code.
// Revision : 1.0 - initial release
// ============================================================================
module carfield_eoc_tap #(
    parameter logic [31:0] IdCode     = 32'h1CA4_F001,
    parameter logic [63:0] EntryReset = 64'h0000_0000_1000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tms_i,
    input  logic        tdi_i,
    output logic        tdo_o,
    output logic        tdo_oe_o,
    input  logic        eoc_valid_i,
    input  logic [31:0] eoc_code_i,
    output logic [63:0] entry_o,
    output logic        run_o
);

    typedef enum logic [3:0] {
        S_TLR        = 4'h0,
        S_RTI        = 4'h1,
        S_SEL_DR     = 4'h2,
        S_CAPTURE_DR = 4'h3,
        S_SHIFT_DR   = 4'h4,
        S_EXIT1_DR   = 4'h5,
        S_PAUSE_DR   = 4'h6,
        S_EXIT2_DR   = 4'h7,
        S_UPDATE_DR  = 4'h8,
        S_SEL_IR     = 4'h9,
        S_CAPTURE_IR = 4'hA,
        S_SHIFT_IR   = 4'hB,
        S_EXIT1_IR   = 4'hC,
        S_PAUSE_IR   = 4'hD,
        S_EXIT2_IR   = 4'hE,
        S_UPDATE_IR  = 4'hF
    } tap_state_t;

    localparam logic [4:0]  c_IR_IDCODE = 5'h01;
    localparam logic [4:0]  c_IR_CTRL   = 5'h11;
    localparam logic [4:0]  c_IR_EOC    = 5'h10;
    localparam logic [31:0] c_IDCODE    = {IdCode[31:1], 1'b1};

    tap_state_t  r_state;
    logic [4:0]  r_ir;
    logic [4:0]  r_ir_sr;
    logic [63:0] r_dr_sr;
    logic [63:0] r_entry;
    logic        r_eoc_sticky;
    logic [31:0] r_eoc_code;
    logic        r_run;

    logic w_update_ctrl;
    logic w_eoc_clear;

    assign w_update_ctrl = (r_state == S_UPDATE_DR) && (r_ir == c_IR_CTRL);
    assign w_eoc_clear   = (r_state == S_UPDATE_DR) && (r_ir == c_IR_EOC) && r_dr_sr[32];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_TLR;
            r_ir         <= c_IR_IDCODE;
            r_ir_sr      <= 5'b0;
            r_dr_sr      <= 64'b0;
            r_entry      <= EntryReset;
            r_eoc_sticky <= 1'b0;
            r_eoc_code   <= 32'b0;
            r_run        <= 1'b0;
        end else begin
            case (r_state)
                S_TLR:        r_state <= tms_i ? S_TLR        : S_RTI;
                S_RTI:        r_state <= tms_i ? S_SEL_DR     : S_RTI;
                S_SEL_DR:     r_state <= tms_i ? S_SEL_IR     : S_CAPTURE_DR;
                S_CAPTURE_DR: r_state <= tms_i ? S_EXIT1_DR   : S_SHIFT_DR;
                S_SHIFT_DR:   r_state <= tms_i ? S_EXIT1_DR   : S_SHIFT_DR;
                S_EXIT1_DR:   r_state <= tms_i ? S_UPDATE_DR  : S_PAUSE_DR;
                S_PAUSE_DR:   r_state <= tms_i ? S_EXIT2_DR   : S_PAUSE_DR;
                S_EXIT2_DR:   r_state <= tms_i ? S_UPDATE_DR  : S_SHIFT_DR;
                S_UPDATE_DR:  r_state <= tms_i ? S_SEL_DR     : S_RTI;
                S_SEL_IR:     r_state <= tms_i ? S_TLR        : S_CAPTURE_IR;
                S_CAPTURE_IR: r_state <= tms_i ? S_EXIT1_IR   : S_SHIFT_IR;
                S_SHIFT_IR:   r_state <= tms_i ? S_EXIT1_IR   : S_SHIFT_IR;
                S_EXIT1_IR:   r_state <= tms_i ? S_UPDATE_IR  : S_PAUSE_IR;
                S_PAUSE_IR:   r_state <= tms_i ? S_EXIT2_IR   : S_PAUSE_IR;
                S_EXIT2_IR:   r_state <= tms_i ? S_UPDATE_IR  : S_SHIFT_IR;
                default:      r_state <= tms_i ? S_SEL_DR     : S_RTI;
            endcase

            case (r_state)
                S_TLR:        r_ir    <= c_IR_IDCODE;
                S_CAPTURE_IR: r_ir_sr <= 5'b00001;
                S_SHIFT_IR:   r_ir_sr <= {tdi_i, r_ir_sr[4:1]};
                S_UPDATE_IR:  r_ir    <= r_ir_sr;
                S_CAPTURE_DR: begin
                    case (r_ir)
                        c_IR_IDCODE: r_dr_sr <= {32'b0, c_IDCODE};
                        c_IR_CTRL:   r_dr_sr <= r_entry;
                        c_IR_EOC:    r_dr_sr <= {31'b0, r_eoc_sticky, r_eoc_code};
                        default:     r_dr_sr <= 64'b0;
                    endcase
                end
                // tdi enters at the MSB of whichever register length IR selects
                S_SHIFT_DR: begin
                    case (r_ir)
                        c_IR_IDCODE: r_dr_sr <= {32'b0, tdi_i, r_dr_sr[31:1]};
                        c_IR_CTRL:   r_dr_sr <= {tdi_i, r_dr_sr[63:1]};
                        c_IR_EOC:    r_dr_sr <= {31'b0, tdi_i, r_dr_sr[32:1]};
                        default:     r_dr_sr <= {63'b0, tdi_i};
                    endcase
                end
                default: ;
            endcase

            r_run <= w_update_ctrl;
            if (w_update_ctrl) begin
                r_entry <= r_dr_sr;
            end

            // a new report always re-arms the flag, even against a clear
            if (eoc_valid_i) begin
                r_eoc_sticky <= 1'b1;
                r_eoc_code   <= eoc_code_i;
            end else if (w_eoc_clear) begin
                r_eoc_sticky <= 1'b0;
            end
        end
    end

    assign tdo_o    = (r_state == S_SHIFT_IR) ? r_ir_sr[0] :
                      (r_state == S_SHIFT_DR) ? r_dr_sr[0] : 1'b0;
    assign tdo_oe_o = (r_state == S_SHIFT_IR) || (r_state == S_SHIFT_DR);
    assign entry_o  = r_entry;
    assign run_o    = r_run;

endmodule
`default_nettype wire

// File: doc/carfield_eoc_tap.md
CARFIELD_EOC_TAP -- requirements
Module: carfield_eoc_tap

Interface
REQ-001 SHALL have parameter IdCode, default 32'h1CA4_F001, 32-bit JTAG IDCODE value (bit 0 fixed 1).
REQ-002 SHALL have parameter EntryReset, default 64'h0000_0000_1000_0000, reset value of the entry register.
REQ-003 SHALL have a single clock and a synchronous, active-high reset (clk_i, rst_i).
REQ-004 clk_i  in  1  the only clock; the TCK-rate clock; all state updates on its rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 tms_i  in  1  JTAG test mode select, sampled at rising clk_i.
REQ-007 tdi_i  in  1  JTAG serial data in, sampled at rising clk_i.
REQ-008 tdo_o  out  1  JTAG serial data out.
REQ-009 tdo_oe_o  out  1  high only in Shift-IR and Shift-DR.
REQ-010 eoc_valid_i  in  1  one-cycle pulse: SoC reports end of computation.
REQ-011 eoc_code_i  in  32  exit code, qualified by eoc_valid_i.
REQ-012 entry_o  out  64  entry address register contents.
REQ-013 run_o  out  1  one-cycle pulse requesting the SoC to start at entry_o.

Function
REQ-014 SHALL implement the 16-state IEEE 1149.1 TAP FSM; one transition per clk_i, driven by tms_i.
REQ-015 Five consecutive cycles with tms_i=1 SHALL reach Test-Logic-Reset from any state.
REQ-016 IR SHALL be 5 bits: IDCODE=5'h01, CTRL=5'h11, EOC=5'h10, BYPASS=5'h1F; any other value SHALL behave as BYPASS.
REQ-017 Capture-IR SHALL load the IR shift register with 5'b00001; Update-IR SHALL copy it into IR; Test-Logic-Reset SHALL set IR to IDCODE.
REQ-018 Capture-DR SHALL load the selected DR: IDCODE->IdCode (32b); BYPASS->1'b0 (1b); EOC->{eoc_sticky, eoc_code_q} (33b); CTRL->entry_q (64b).
REQ-019 Each Shift state cycle SHALL shift the selected register right one bit, with tdi_i entering the MSB.
REQ-020 tdo_o SHALL be the LSB of the selected shift register in Shift-IR/Shift-DR, else 0; combinational from registered state.
REQ-021 Update-DR with IR=CTRL SHALL load entry_q from the 64-bit shift register and assert run_o for exactly the following clk_i cycle.
REQ-022 Update-DR with IR=EOC and shifted bit 32=1 SHALL clear eoc_sticky (write-1-to-clear); bit 32=0 SHALL leave it unchanged; code bits are read-only.
REQ-023 eoc_valid_i=1 SHALL set eoc_sticky and load eoc_code_q from eoc_code_i in the next cycle, even when eoc_sticky is already set (latest code wins).
REQ-024 When set and clear occur in the same cycle, set SHALL win.
REQ-025 Update-DR with IR=IDCODE or BYPASS SHALL have no side effect.
REQ-026 Test-Logic-Reset SHALL NOT alter entry_q, eoc_sticky or eoc_code_q.
REQ-027 Exiting a Shift state through Exit1/Pause/Exit2 without reaching Update SHALL leave IR, entry_q and eoc_sticky unchanged.

Reset
REQ-028 rst_i=1 SHALL force: TAP state Test-Logic-Reset; IR=IDCODE; shift registers 0; entry_q=EntryReset; eoc_sticky=0; eoc_code_q=0; run_o=0; tdo_o=0; tdo_oe_o=0.
REQ-029 rst_i asserted mid-shift SHALL abort the shift with no update and take effect on the next rising edge.
REQ-030 rst_i SHALL take priority over eoc_valid_i in the same cycle.

Verification
REQ-031 Reset, then go to Shift-DR and shift 32 bits -> tdo_o sequence LSB-first equals 32'h1CA4_F001.
REQ-032 Load IR=CTRL, then shift 64'h0000_0000_8000_1234 and pass Update-DR -> entry_o=64'h0000_0000_8000_1234; run_o high exactly 1 cycle.
REQ-033 Pulse eoc_valid_i with eoc_code_i=32'h0000_0001, then load IR=EOC and capture/shift 33 bits -> read 33'h1_0000_0001; shift in bit32=1 and Update -> re-read gives 33'h0_0000_0001.
REQ-034 Assert eoc_valid_i in the same cycle as an EOC clearing Update-DR -> eoc_sticky stays 1.
REQ-035 Load IR=5'h07 and shift pattern 1011 -> tdo_o reproduces the pattern delayed by one cycle, preceded by the captured 0.
REQ-036 From Shift-DR drive tms_i=1 for 5 cycles -> Test-Logic-Reset; IR=IDCODE; entry_o unchanged.
